fir_tap_mux_seq: RTL and testbench
==================================

Name: fir_tap_mux_seq

Overview:
Parametrised, registered N:1 word multiplexer for the FIR datapath. It generalises the fixed 4:1 single-bit mux to N channels of W bits, with a valid/ready handshake on both sides. It has two modes:
- Direct: one selected word per input bundle.
- Scan: serialises all N words of a bundle, channel 0 first.
It sits between the tap delay line and the shared multiply-accumulate (MAC) unit, so one MAC can be time-shared across taps.

Parameters:
N, 4, number of input channels (taps); N >= 2
W, 8, bits per channel word
SW, clog2(N), width of sel and out_chan (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  N*W  packed bundle; channel k occupies bits [k*W +: W]
in_valid  input  1  bundle valid
in_ready  output  1  block can accept a bundle this cycle
mode  input  1  0 = direct, 1 = scan; sampled only on bundle accept
sel  input  SW  channel index for direct mode; sampled on accept
out_data  output  W  selected word (registered)
out_chan  output  SW  channel index of out_data
out_last  output  1  final word of the current bundle
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts the word
sel_err  output  1  one-cycle pulse: direct-mode sel >= N was accepted

Behaviour:
- Reset: the reset is synchronous and active-low (rst_n low at a rising clk edge).
  - State goes to IDLE.
  - out_data, out_chan, out_last, out_valid, sel_err, the hold register and the scan counter all go to 0.
  - in_ready is 0 during reset.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - The output register may load when !out_valid | out_ready (register free).
  - While out_valid=1 and out_ready=0, out_data, out_chan and out_last hold stable.
- in_ready = (state == IDLE) & (!out_valid | out_ready). Combinational; it has no path from in_valid.
- FSM has two states, IDLE and SCAN.
  - IDLE, accept with mode=0 (direct):
    - out_data <= in_data[sel*W +: W], out_chan <= sel, out_last <= 1, out_valid <= 1.
    - Latency: 1 cycle. State stays IDLE.
  - IDLE, accept with mode=1 (scan):
    - hold <= in_data.
    - out_data <= channel 0, out_chan <= 0, out_last <= 0, out_valid <= 1.
    - cnt <= 1, state -> SCAN.
  - SCAN, whenever the output register is free:
    - load hold[cnt] into out_data, out_chan <= cnt, out_last <= (cnt == N-1).
    - If cnt == N-1: state -> IDLE. Otherwise cnt <= cnt + 1.
    - Back-to-back rate is one word per cycle when out_ready stays high.
  - IDLE with no accept and the register free: out_valid <= 0.
- Throughput:
  - Direct mode: one bundle per cycle.
  - Scan mode: one bundle per N cycles. in_ready is low in SCAN, so a new bundle cannot arrive before the last word is loaded.
- Out-of-range sel (sel >= N, possible when N is not a power of 2), direct mode:
  - Word is still emitted with out_data = 0, out_chan = sel, out_last = 1.
  - sel_err = 1 for exactly that cycle.
- Mid-operation changes: mode and sel changes while in SCAN, or while not accepting, have no effect.
- Reset asserted mid-scan: remaining words are dropped; outputs return to reset values on that edge.
- Width: no arithmetic on data. cnt is SW bits and never exceeds N-1.

Decomposition:
- Shared package/header fir_pkg:
  - state encodings ST_IDLE = 1'b0, ST_SCAN = 1'b1;
  - a clog2 constant function used to derive SW.
- One combinational sub-module, fir_mux_n1 #(N, W):
  - packed N*W input, SW-bit select, W-bit output;
  - output 0 when select >= N.
  - Instantiated twice: once on in_data (direct / channel 0) and once on hold (scan). This replaces the tree of 2:1 mux instances.

Test Plan:
- Direct, N=4, W=8, out_ready=1: in_data = 0x44332211, sel = 2, mode = 0 -> next cycle out_data = 0x33, out_chan = 2, out_last = 1, out_valid = 1; in_ready stays 1 for the following bundle.
- Scan, out_ready=1: in_data = 0xDDCCBBAA, mode = 1 -> over 4 consecutive cycles out_data = AA, BB, CC, DD with out_chan = 0..3; out_last only on DD; in_ready = 0 for cycles 1-3, then 1.
- Scan with backpressure: out_ready = 0 for 3 cycles while BB is shown -> BB and chan = 1 held stable; sequence resumes CC, DD with no loss and no duplication.
- N=3, direct, sel = 3 -> out_data = 0, out_chan = 3, out_last = 1, sel_err pulses for one cycle; the next valid sel = 1 gives channel 1 data and sel_err = 0.
- Reset mid-scan: rst_n low for 1 cycle after CC is emitted -> out_valid = 0 and state IDLE on that edge; DD never appears; a new direct bundle is accepted correctly afterwards.
- Mode/sel toggling during SCAN -> emitted sequence is unchanged; the next IDLE accept uses the new mode and sel.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR tap multiplexer: FSM encodings and width helper.
package fir_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   // Smallest r with 2**r >= v; used to size channel indices.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_tap_mux_seq_if.sv
// Input bundle / output word handshake bus of the FIR tap multiplexer.
interface fir_tap_mux_seq_if import fir_pkg::*; #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) ();
   localparam int unsigned SW = clog2(N);

   logic [N*W-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_chan;
   logic           out_last;
   logic           out_valid;
   logic           out_ready;
   logic           sel_err;

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_last, out_valid, sel_err
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_last, out_valid, sel_err
   );
endinterface

// File: rtl/fir_tap_mux_seq_mux_n1.sv
// Combinational N:1 word selector; out-of-range selects yield zero.
module fir_mux_n1 import fir_pkg::*; #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic [N*W-1:0]      data_i,
   input  logic [clog2(N)-1:0] sel_i,
   output logic [W-1:0]        data_o
);
   localparam int unsigned SW = clog2(N);

   always_comb begin
      data_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (sel_i == SW'(k)) data_o = data_i[k*W +: W];
      end
   end
endmodule

// File: rtl/fir_tap_mux_seq.sv
// Registered N:1 tap multiplexer: direct word select or full-bundle scan, valid/ready both sides.
module fir_tap_mux_seq import fir_pkg::*; #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input logic              clk,
   input logic              rst_n,
   fir_tap_mux_seq_if.slave bus
);
   localparam int unsigned   SW      = clog2(N);
   localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

   logic [0:0]     state_q, state_d;
   logic [SW-1:0]  cnt_q, cnt_d;
   logic [N*W-1:0] hold_q, hold_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic [SW-1:0]  out_chan_q, out_chan_d;
   logic           out_last_q, out_last_d;
   logic           out_valid_q, out_valid_d;
   logic           sel_err_q, sel_err_d;

   logic           reg_free;
   logic           accept;
   logic [SW-1:0]  dsel;
   logic [W-1:0]   dword;
   logic [W-1:0]   sword;

   assign reg_free     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = rst_n && (state_q == ST_IDLE) && reg_free;
   assign accept       = bus.in_valid && bus.in_ready;
   // Scan bundles start at channel 0, so the input-side mux doubles as the scan head.
   assign dsel         = bus.mode ? '0 : bus.sel;

   fir_mux_n1 #(.N(N), .W(W)) u_mux_in (
      .data_i (bus.in_data),
      .sel_i  (dsel),
      .data_o (dword)
   );

   fir_mux_n1 #(.N(N), .W(W)) u_mux_hold (
      .data_i (hold_q),
      .sel_i  (cnt_q),
      .data_o (sword)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      sel_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               out_data_d  = dword;
               out_valid_d = 1'b1;
               if (bus.mode) begin
                  hold_d     = bus.in_data;
                  out_chan_d = '0;
                  out_last_d = 1'b0;
                  cnt_d      = SW'(1);
                  state_d    = ST_SCAN;
               end else begin
                  out_chan_d = bus.sel;
                  out_last_d = 1'b1;
                  sel_err_d  = (32'(bus.sel) >= N);
               end
            end else if (reg_free) begin
               out_valid_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (reg_free) begin
               out_data_d  = sword;
               out_chan_d  = cnt_q;
               out_last_d  = (cnt_q == LAST_CH);
               out_valid_d = 1'b1;
               if (cnt_q == LAST_CH) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + SW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_fir_tap_mux_seq.sv
// Bench for fir_tap_mux_seq: N=4 and N=3 instances share stimulus, each checked against a word-queue model.
module tb_fir_tap_mux_seq;
   typedef struct { logic [7:0] data; int chan; logic last; } exp_t;
   typedef struct { logic [1:0] sel; logic [31:0] din; logic [7:0] exp4; logic [7:0] exp3; logic err3; } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din;
   logic        vld, md, ord;
   logic [1:0]  sl;

   int   checks = 0;
   int   errors = 0;
   exp_t q[2][$];
   logic err_exp[2];

   always #5 clk = ~clk;

   fir_tap_mux_seq_if #(.N(4), .W(8)) b4 ();
   fir_tap_mux_seq_if #(.N(3), .W(8)) b3 ();

   assign b4.in_data   = din;
   assign b4.in_valid  = vld;
   assign b4.mode      = md;
   assign b4.sel       = sl;
   assign b4.out_ready = ord;
   assign b3.in_data   = din[23:0];
   assign b3.in_valid  = vld;
   assign b3.mode      = md;
   assign b3.sel       = sl;
   assign b3.out_ready = ord;

   fir_tap_mux_seq #(.N(4), .W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   fir_tap_mux_seq #(.N(3), .W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Ready whenever every word of earlier bundles has reached the output register and it can be freed.
   function automatic bit mready(int d);
      return rst_n && ((q[d].size() == 0) || (q[d].size() == 1 && ord));
   endfunction

   task automatic check_outputs(int d);
      logic       ov, ol, oe;
      logic [7:0] od;
      logic [1:0] oc;
      if (d == 0) begin
         ov = b4.out_valid; ol = b4.out_last; oe = b4.sel_err; od = b4.out_data; oc = b4.out_chan;
      end else begin
         ov = b3.out_valid; ol = b3.out_last; oe = b3.sel_err; od = b3.out_data; oc = b3.out_chan;
      end
      chk($sformatf("out_valid[%0d]", d), 32'(ov), 32'(q[d].size() != 0));
      if (q[d].size() != 0) begin
         chk($sformatf("out_data[%0d]", d), 32'(od), 32'(q[d][0].data));
         chk($sformatf("out_chan[%0d]", d), 32'(oc), 32'(q[d][0].chan));
         chk($sformatf("out_last[%0d]", d), 32'(ol), 32'(q[d][0].last));
      end
      chk($sformatf("sel_err[%0d]", d), 32'(oe), 32'(err_exp[d]));
   endtask

   task automatic cycle();
      bit          acc[2];
      bit          xfr[2];
      logic [1:0]  rdy;
      logic [31:0] x;
      int          n;
      exp_t        e;
      #1;
      rdy = {b3.in_ready, b4.in_ready};
      for (int d = 0; d < 2; d++) begin
         acc[d] = vld && mready(d);
         xfr[d] = (q[d].size() != 0) && ord;
         chk($sformatf("in_ready[%0d]", d), 32'(rdy[d]), 32'(mready(d)));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         n = (d == 0) ? 4 : 3;
         x = (d == 0) ? din : {8'h00, din[23:0]};
         err_exp[d] = 1'b0;
         if (!rst_n) begin
            q[d].delete();
         end else begin
            if (xfr[d]) void'(q[d].pop_front());
            if (acc[d]) begin
               if (md) begin
                  for (int k = 0; k < n; k++) begin
                     e.data = x[k*8 +: 8]; e.chan = k; e.last = (k == n - 1);
                     q[d].push_back(e);
                  end
               end else begin
                  e.data = (int'(sl) < n) ? x[int'(sl)*8 +: 8] : 8'h00;
                  e.chan = int'(sl);
                  e.last = 1'b1;
                  q[d].push_back(e);
                  err_exp[d] = (int'(sl) >= n);
               end
            end
         end
      end
      #1;
      check_outputs(0);
      check_outputs(1);
   endtask

   task automatic drive(input logic r, input logic v, input logic m, input logic [1:0] s,
                        input logic [31:0] d, input logic rd);
      @(negedge clk);
      rst_n = r; vld = v; md = m; sl = s; din = d; ord = rd;
      cycle();
   endtask

   task automatic idle(input int k);
      repeat (k) drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
   endtask

   initial begin
      vec_t       tbl[4];
      logic [7:0] se[4];
      rst_n = 1'b0; vld = 1'b0; md = 1'b0; sl = 2'd0; din = '0; ord = 1'b1;
      err_exp[0] = 1'b0; err_exp[1] = 1'b0;
      repeat (2) @(posedge clk);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);

      // Direct-mode vectors; sel=3 is out of range only for the N=3 instance.
      tbl[0] = '{2'd2, 32'h44332211, 8'h33, 8'h33, 1'b0};
      tbl[1] = '{2'd3, 32'h44332211, 8'h44, 8'h00, 1'b1};
      tbl[2] = '{2'd1, 32'h44332211, 8'h22, 8'h22, 1'b0};
      tbl[3] = '{2'd0, 32'hA5B6C7D8, 8'hD8, 8'hD8, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, tbl[i].sel, tbl[i].din, 1'b1);
         chk("tbl_data4", 32'(b4.out_data), 32'(tbl[i].exp4));
         chk("tbl_chan4", 32'(b4.out_chan), 32'(tbl[i].sel));
         chk("tbl_data3", 32'(b3.out_data), 32'(tbl[i].exp3));
         chk("tbl_err3",  32'(b3.sel_err),  32'(tbl[i].err3));
         chk("tbl_chan3", 32'(b3.out_chan), 32'(tbl[i].sel));
      end

      se[0] = 8'hAA; se[1] = 8'hBB; se[2] = 8'hCC; se[3] = 8'hDD;
      idle(5);
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
         chk("scan_data", 32'(b4.out_data), 32'(se[i]));
         chk("scan_chan", 32'(b4.out_chan), 32'(i));
         chk("scan_last", 32'(b4.out_last), 32'(i == 3));
      end

      idle(5);
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      repeat (3) begin
         drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
         chk("bp_hold_data", 32'(b4.out_data), 32'h0000_00BB);
         chk("bp_hold_chan", 32'(b4.out_chan), 32'd1);
      end
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("bp_resume_cc", 32'(b4.out_data), 32'h0000_00CC);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("bp_resume_dd", 32'(b4.out_data), 32'h0000_00DD);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("bp_drained", 32'(b4.out_valid), 32'd0);

      idle(5);
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("rst_pre_cc", 32'(b4.out_data), 32'h0000_00CC);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("rst_valid", 32'(b4.out_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      chk("rst_no_dd", 32'(b4.out_valid), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h11223344, 1'b1);
      chk("rst_after_direct", 32'(b4.out_data), 32'h0000_0022);

      idle(5);
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 2'd3, 32'h87654321, 1'b1);
      chk("tog_bb", 32'(b4.out_data), 32'h0000_00BB);
      drive(1'b1, 1'b1, 1'b0, 2'd1, 32'h12345678, 1'b1);
      chk("tog_cc", 32'(b4.out_data), 32'h0000_00CC);
      drive(1'b1, 1'b1, 1'b0, 2'd1, 32'h12345678, 1'b1);
      chk("tog_dd", 32'(b4.out_data), 32'h0000_00DD);
      drive(1'b1, 1'b1, 1'b0, 2'd1, 32'h12345678, 1'b1);
      chk("tog_new_sel", 32'(b4.out_data), 32'h0000_0056);
      chk("tog_new_last", 32'(b4.out_last), 32'd1);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) != 0);
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
